// File: rtl/data_path_stk.sv
// Hack-style data path: A register, NUM_D data registers, internal ALU and a PC with a call/return stack.
// Define DATA_PATH_STK_CARRY_EN to add the combinational co_o/ov_o adder flags.
module data_path_stk #(
    parameter int WIDTH       = 16,
    parameter int PC_STEP     = 2,
    parameter int NUM_D       = 4,
    parameter int STACK_DEPTH = 8,
    localparam int DW         = $clog2(NUM_D),
    localparam int SW         = $clog2(STACK_DEPTH)
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] inM_i,
    input  logic [WIDTH-1:0] instruction_i,
    input  logic             selA_i,
    input  logic             enA_i,
    input  logic             selALU_i,
    input  logic [DW-1:0]    selD_i,
    input  logic             enD_i,
    input  logic             enPC_i,
    input  logic             loadPC_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic             na_i,
    input  logic             za_i,
    input  logic             nb_i,
    input  logic             zb_i,
    input  logic             f_i,
    input  logic             no_i,
    input  logic             halt_i,
    input  logic             stall_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] outM_o,
    output logic [WIDTH-1:0] addressM_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] regD_o,
    output logic             zr_o,
    output logic             zn_o,
    output logic [SW:0]      depth_o,
`ifdef DATA_PATH_STK_CARRY_EN
    output logic             co_o,
    output logic             ov_o,
`endif
    output logic             stk_ovf_o,
    output logic             stk_unf_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] d_q [NUM_D];
    logic [WIDTH-1:0] stk_q [STACK_DEPTH];
    logic [SW:0]      depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] x_sel, y_sel, x_op, y_op, add_res, alu_res;
    logic             upd, pc_upd, d_wr, push;
    logic [WIDTH-1:0] pc_inc;
    logic [SW-1:0]    push_idx, pop_idx;

    always_comb begin
        x_sel = d_q[selD_i];
        y_sel = selALU_i ? inM_i : a_q;
        x_op  = za_i ? '0 : x_sel;
        x_op  = na_i ? ~x_op : x_op;
        y_op  = zb_i ? '0 : y_sel;
        y_op  = nb_i ? ~y_op : y_op;
    end

`ifdef DATA_PATH_STK_CARRY_EN
    logic [WIDTH:0] sum_ext;
    assign sum_ext = {1'b0, x_op} + {1'b0, y_op};
    assign add_res = sum_ext[WIDTH-1:0];
    assign co_o    = f_i & sum_ext[WIDTH];
    // Signed overflow: same-sign operands producing an opposite-sign sum.
    assign ov_o    = f_i & (x_op[WIDTH-1] == y_op[WIDTH-1]) & (sum_ext[WIDTH-1] != x_op[WIDTH-1]);
`else
    assign add_res = x_op + y_op;
`endif

    always_comb begin
        alu_res = f_i ? add_res : (x_op & y_op);
        alu_res = no_i ? ~alu_res : alu_res;
    end

    assign outM_o     = alu_res;
    assign zr_o       = (alu_res == '0);
    assign zn_o       = alu_res[WIDTH-1];
    assign addressM_o = a_q;
    assign pc_o       = pc_q;
    assign regD_o     = d_q[selD_i];
    assign depth_o    = depth_q;
    assign stk_ovf_o  = ovf_q;
    assign stk_unf_o  = unf_q;

    assign upd      = ~stall_i;
    assign pc_upd   = upd & enPC_i & ~halt_i;
    assign d_wr     = upd & enD_i;
    assign pc_inc   = pc_q + WIDTH'(PC_STEP);
    assign push_idx = SW'(depth_q);
    assign pop_idx  = SW'(depth_q - 1'b1);

    always_comb begin
        a_d     = a_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (upd && enA_i) begin
            a_d = selA_i ? instruction_i : alu_res;
        end
        // Clear first so an error raised in the same cycle wins.
        if (upd && !halt_i && clr_err_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (pc_upd) begin
            if (ret_i) begin
                if (depth_q != '0) begin
                    pc_d    = stk_q[pop_idx];
                    depth_d = depth_q - 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
            end else if (call_i) begin
                if (depth_q != (SW+1)'(STACK_DEPTH)) begin
                    push    = 1'b1;
                    pc_d    = a_q;
                    depth_d = depth_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (loadPC_i) begin
                pc_d = a_q;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            a_q     <= '0;
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < NUM_D; i++) begin
                d_q[i] <= '0;
            end
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            a_q     <= a_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (d_wr) begin
                d_q[selD_i] <= alu_res;
            end
            if (push) begin
                stk_q[push_idx] <= pc_inc;
            end
        end
    end

endmodule
